// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the execute stage.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle and holds the HI/LO results.
// Signed operations work on magnitudes and fix the sign in a final cycle.
module muldiv_unit #(
    parameter int WORD_W = 32,
    localparam int CNT_W = $clog2(WORD_W) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              flush,
    input  logic              wr_hi,
    input  logic              wr_lo,
    output logic              busy,
    output logic              done,
    output logic              divzero,
    output logic [WORD_W-1:0] HI,
    output logic [WORD_W-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Conditional two's-complement negation of a single word.
    function automatic logic [WORD_W-1:0] cneg_word(input logic [WORD_W-1:0] v,
                                                    input logic              en);
        logic [WORD_W-1:0] r;
        if (en) begin
            r = (~v) + {{(WORD_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negation of a double-width product.
    function automatic logic [2*WORD_W-1:0] cneg_dword(input logic [2*WORD_W-1:0] v,
                                                       input logic                en);
        logic [2*WORD_W-1:0] r;
        if (en) begin
            r = (~v) + {{(2*WORD_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Architectural and working state.
    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [2*WORD_W-1:0] acc_q,     acc_d;     // product, or {remainder, quotient}
    logic [WORD_W-1:0]   opnd_q,    opnd_d;    // |multiplicand| or |divisor|
    logic                is_div_q,  is_div_d;
    logic                neg_lo_q,  neg_lo_d;  // product / quotient sign
    logic                neg_hi_q,  neg_hi_d;  // remainder sign (divide only)
    logic [WORD_W-1:0]   hi_q,      hi_d;
    logic [WORD_W-1:0]   lo_q,      lo_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                divzero_q, divzero_d;

    // Helper nets for operand conditioning and one iteration step.
    logic                a_neg_s;
    logic                b_neg_s;
    logic [WORD_W-1:0]   abs_a_s;
    logic [WORD_W-1:0]   abs_b_s;
    logic                launch_s;
    logic                idle_like_s;
    logic [WORD_W:0]     mul_sum_s;
    logic [WORD_W:0]     rem_shift_s;
    logic [WORD_W-1:0]   rem_diff_s;
    logic                rem_ge_s;
    logic [2*WORD_W-1:0] prod_fix_s;

    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divzero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

    // Operand magnitudes, launch qualification and the per-cycle datapath step.
    always_comb begin
        a_neg_s     = (op[0] == 1'b0) && A[WORD_W-1];
        b_neg_s     = (op[0] == 1'b0) && B[WORD_W-1];
        abs_a_s     = cneg_word(A, a_neg_s);
        abs_b_s     = cneg_word(B, b_neg_s);
        idle_like_s = (state_q == S_IDLE) || (state_q == S_DONE);
        launch_s    = start && !flush && idle_like_s;

        // Shift-add: add the multiplicand to the upper half when the current
        // multiplier bit (LSB of the accumulator) is set, then shift right.
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*WORD_W-1:WORD_W]} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*WORD_W-1:WORD_W]};
        end

        // Restoring division: shift the next dividend bit into the remainder
        // and subtract the divisor if it fits.
        rem_shift_s = {acc_q[2*WORD_W-1:WORD_W], acc_q[WORD_W-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, opnd_q});
        rem_diff_s  = rem_shift_s[WORD_W-1:0] - opnd_q;

        prod_fix_s  = cneg_dword(acc_q, neg_lo_q);
    end

    // Next-state and next-register computation for the whole unit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch_s) begin
                    divzero_d = 1'b0;
                    if (op[1] && (B == {WORD_W{1'b0}})) begin
                        // Divide by zero short-circuits straight to DONE.
                        state_d   = S_DONE;
                        hi_d      = A;
                        lo_d      = {WORD_W{1'b1}};
                        divzero_d = 1'b1;
                    end else begin
                        state_d  = S_CALC;
                        cnt_d    = {CNT_W{1'b0}};
                        is_div_d = op[1];
                        neg_lo_d = a_neg_s ^ b_neg_s;
                        if (op[1]) begin
                            acc_d    = {{WORD_W{1'b0}}, abs_a_s};
                            opnd_d   = abs_b_s;
                            neg_hi_d = a_neg_s;
                        end else begin
                            acc_d    = {{WORD_W{1'b0}}, abs_b_s};
                            opnd_d   = abs_a_s;
                            neg_hi_d = a_neg_s ^ b_neg_s;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
                // Move-to writes take priority over any same-edge result.
                if (wr_hi) begin
                    hi_d = A;
                end else begin
                    hi_d = hi_d;
                end
                if (wr_lo) begin
                    lo_d = A;
                end else begin
                    lo_d = lo_d;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (rem_ge_s) begin
                            acc_d = {rem_diff_s, acc_q[WORD_W-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_shift_s[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum_s, acc_q[WORD_W-1:1]};
                    end
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // The accumulator is the staging register; the signed
                    // fix-up lands in HI/LO on the FIX->DONE edge.
                    state_d = S_DONE;
                    if (is_div_q) begin
                        hi_d = cneg_word(acc_q[2*WORD_W-1:WORD_W], neg_hi_q);
                        lo_d = cneg_word(acc_q[WORD_W-1:0], neg_lo_q);
                    end else begin
                        hi_d = prod_fix_s[2*WORD_W-1:WORD_W];
                        lo_d = prod_fix_s[WORD_W-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State register with asynchronous reset; status outputs are registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WORD_W){1'b0}};
            opnd_q    <= {WORD_W{1'b0}};
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            hi_q      <= {WORD_W{1'b0}};
            lo_q      <= {WORD_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WORD_W = 32) with hand-computed results.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // edges after the start edge until DONE

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic          CLK;
    logic          RST;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          flush;
    logic          wr_hi;
    logic          wr_lo;
    logic          busy;
    logic          done;
    logic          divzero;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int tests;
    int fails;

    muldiv_unit #(.WORD_W(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .HI      (HI),
        .LO      (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Wait n edges; done must stay low before them and be high after.
    task automatic wait_lat(input string tag, input int n);
        logic early;
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done === 1'b1) early = 1'b1;
            step();
        end
        check({tag, " early_done"}, {63'd0, early}, 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int n,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        launch(o, a, b);
        wait_lat(tag, n);
        check({tag, " HI"}, {32'd0, HI}, {32'd0, exp_hi});
        check({tag, " LO"}, {32'd0, LO}, {32'd0, exp_lo});
    endtask

    initial begin
        logic seen;
        tests = 0;
        fails = 0;
        RST   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        flush = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        #1;
        check("rst busy",    {63'd0, busy},    64'd0);
        check("rst done",    {63'd0, done},    64'd0);
        check("rst divzero", {63'd0, divzero}, 64'd0);
        check("rst HI",      {32'd0, HI},      64'd0);
        check("rst LO",      {32'd0, LO},      64'd0);
        step();
        step();
        RST = 1'b0;
        step();

        // MULT -1 * 2 with exact latency; done is a single-cycle pulse.
        launch(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult busy", {63'd0, busy}, 64'd1);
        wait_lat("mult", LAT);
        check("mult HI", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        check("mult LO", {32'd0, LO}, {32'd0, 32'hFFFF_FFFE});
        step();
        check("done pulse", {63'd0, done}, 64'd0);
        check("idle busy",  {63'd0, busy}, 64'd0);

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, LAT, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult mn", OP_MULT, 32'h8000_0000, 32'h8000_0000, LAT, 32'h4000_0000, 32'h0000_0000);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, LAT, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu 7/2", OP_DIVU, 32'h0000_0007, 32'h0000_0002, LAT, 32'h0000_0001, 32'h0000_0003);
        run_op("div mn/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 32'h0000_0000, 32'h8000_0000);

        // Divide by zero: done right after the start edge, divzero sticky.
        run_op("divz", OP_DIVU, 32'h1234_5678, 32'h0000_0000, 0, 32'h1234_5678, 32'hFFFF_FFFF);
        check("divz flag", {63'd0, divzero}, 64'd1);
        step();
        check("divz sticky", {63'd0, divzero}, 64'd1);
        check("divz pulse",  {63'd0, done},    64'd0);
        launch(OP_DIVU, 32'h0000_0007, 32'h0000_0002);
        check("divz clear", {63'd0, divzero}, 64'd0);
        wait_lat("divu2", LAT);
        check("divu2 LO", {32'd0, LO}, {32'd0, 32'h0000_0003});
        step();

        // Flush at CALC cycle 5: back to IDLE, no done, HI/LO untouched.
        launch(OP_MULTU, 32'h0000_0003, 32'h0000_0005);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush done", {63'd0, done}, 64'd0);
        check("flush HI", {32'd0, HI}, {32'd0, 32'h0000_0001});
        check("flush LO", {32'd0, LO}, {32'd0, 32'h0000_0003});
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done === 1'b1) seen = 1'b1;
            step();
        end
        check("flush no done", {63'd0, seen}, 64'd0);

        // Move-to writes while idle.
        A = 32'h1111_1111;
        wr_hi = 1'b1;
        step();
        wr_hi = 1'b0;
        check("mthi HI", {32'd0, HI}, {32'd0, 32'h1111_1111});
        check("mthi LO", {32'd0, LO}, {32'd0, 32'h0000_0003});

        // Start and wr_hi while busy are ignored; operands were latched.
        launch(OP_MULTU, 32'h0000_0002, 32'h0000_0003);
        start = 1'b1;
        op    = OP_DIVU;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_0001;
        wr_hi = 1'b1;
        step();
        start = 1'b0;
        wr_hi = 1'b0;
        check("busy mthi", {32'd0, HI}, {32'd0, 32'h1111_1111});
        wait_lat("busy start", LAT - 1);
        check("latched HI", {32'd0, HI}, {32'd0, 32'h0000_0000});
        check("latched LO", {32'd0, LO}, {32'd0, 32'h0000_0006});

        // Back-to-back: start in the DONE cycle, second result 34 cycles later.
        run_op("b2b1", OP_MULTU, 32'h0000_0003, 32'h0000_0005, LAT, 32'h0000_0000, 32'h0000_000F);
        run_op("b2b2", OP_DIVU, 32'h0000_0064, 32'h0000_0007, LAT, 32'h0000_0002, 32'h0000_000E);

        // MTLO in DONE overrides LO only.
        A     = 32'h5555_5555;
        wr_lo = 1'b1;
        step();
        wr_lo = 1'b0;
        check("done mtlo LO", {32'd0, LO}, {32'd0, 32'h5555_5555});
        check("done mtlo HI", {32'd0, HI}, {32'd0, 32'h0000_0002});

        // Asynchronous reset in the middle of a MULTU.
        launch(OP_MULTU, 32'h0000_0009, 32'h0000_0009);
        for (int i = 0; i < 9; i++) step();
        #2;
        RST = 1'b1;
        #1;
        check("arst busy", {63'd0, busy}, 64'd0);
        check("arst HI", {32'd0, HI}, 64'd0);
        check("arst LO", {32'd0, LO}, 64'd0);
        #2;
        RST = 1'b0;
        step();

        run_op("post rst", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
